// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: RAM pass-through plus an MMIO register block
// whose TX_DATA register feeds a FIFO drained by a valid/ready stream.
module dmem_mmio_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_AW     = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wren,
    input  logic [31:0]           address_dmem,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q_dmem,
    output logic                  ram_wEn,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0] ram_dataIn,
    input  logic [DATA_WIDTH-1:0] ram_dataOut,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready
);

    logic                  ram_hit;
    logic                  mmio_hit;
    logic [3:0]            mmio_off;
    logic                  tx_push;
    logic                  status_wr;
    logic                  cycles_wr;
    logic                  scratch_wr;
    logic                  push_ok;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW:0]      count;
    logic                  overflow;
    logic [31:0]           cycles;
    logic [DATA_WIDTH-1:0] scratch;
    logic [DATA_WIDTH-1:0] status;
    logic [DATA_WIDTH-1:0] mmio_rd;
    logic [1:0]            sel_q;
    logic [DATA_WIDTH-1:0] mmio_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    assign ram_hit    = (address_dmem[31:RAM_AW] == '0);
    assign mmio_hit   = (address_dmem[31:4] == 28'h0000100);
    assign mmio_off   = address_dmem[3:0];
    assign tx_push    = wren & mmio_hit & (mmio_off == 4'h0);
    assign status_wr  = wren & mmio_hit & (mmio_off == 4'h1);
    assign cycles_wr  = wren & mmio_hit & (mmio_off == 4'h2);
    assign scratch_wr = wren & mmio_hit & (mmio_off == 4'h3);

    assign ram_wEn    = wren & ram_hit;
    assign ram_addr   = address_dmem[RAM_AW-1:0];
    assign ram_dataIn = data;

    assign empty    = (count == '0);
    assign full     = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign tx_valid = ~empty;
    assign tx_data  = fifo_mem[rd_ptr];
    assign pop      = tx_valid & tx_ready;
    // A push into a full FIFO only lands if a pop frees a slot that cycle.
    assign push_ok  = tx_push & (~full | pop);

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wr_ptr] <= data;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (tx_push & full & ~pop) overflow <= 1'b1;
            else if (status_wr)        overflow <= 1'b0;
        end
    end

    // Cycle counter and scratch register; a CYCLES write beats the increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycles  <= '0;
            scratch <= '0;
        end else begin
            cycles <= cycles_wr ? 32'd0 : cycles + 32'd1;
            if (scratch_wr) scratch <= data;
        end
    end

    // Pack the status word.
    always_comb begin
        status                = '0;
        status[0]             = empty;
        status[1]             = full;
        status[2]             = overflow;
        status[3+FIFO_AW:3]   = count;
    end

    // Select the MMIO read value from current (pre-write) state.
    always_comb begin
        mmio_rd = '0;
        case (mmio_off)
            4'h1:    mmio_rd = status;
            4'h2:    mmio_rd = DATA_WIDTH'(cycles);
            4'h3:    mmio_rd = scratch;
            default: mmio_rd = '0;
        endcase
    end

    // Register region select and MMIO data to match RAM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_q  <= 2'b00;
            mmio_q <= '0;
        end else begin
            sel_q  <= {ram_hit, mmio_hit};
            mmio_q <= mmio_rd;
        end
    end

    // Load data mux.
    always_comb begin
        q_dmem = '0;
        if (sel_q[1])      q_dmem = ram_dataOut;
        else if (sel_q[0]) q_dmem = mmio_q;
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder with a behavioural
// registered-read RAM attached to the RAM port.
module tb_dmem_mmio_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;
    logic        ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn;
    logic [31:0] ram_dataOut;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd;
    logic [31:0] ram_mem [4096];

    always #5 clock = ~clock;

    dmem_mmio_responder dut (
        .clock        (clock),
        .reset        (reset),
        .wren         (wren),
        .address_dmem (address_dmem),
        .data         (data),
        .q_dmem       (q_dmem),
        .ram_wEn      (ram_wEn),
        .ram_addr     (ram_addr),
        .ram_dataIn   (ram_dataIn),
        .ram_dataOut  (ram_dataOut),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = 32'h0;
    end

    always @(posedge clock) begin
        if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        wren = 1'b1;
        address_dmem = a;
        data = d;
        tick();
        wren = 1'b0;
        address_dmem = 32'h0000_0F00;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] v);
        wren = 1'b0;
        address_dmem = a;
        tick();
        v = q_dmem;
        address_dmem = 32'h0000_0F00;
    endtask

    initial begin
        reset = 1'b1;
        wren = 1'b0;
        address_dmem = 32'h0000_0F00;
        data = 32'h0;
        tx_ready = 1'b0;
        #1;
        check("rst_q", q_dmem, 32'h0);
        check("rst_valid", {31'h0, tx_valid}, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        load(32'h1001, rd);
        check("rst_status", rd, 32'h1);

        // RAM store then load
        wren = 1'b1;
        address_dmem = 32'h5;
        data = 32'h1234;
        #1;
        check("ram_wen_hi", {31'h0, ram_wEn}, 32'h1);
        check("ram_addr", {20'h0, ram_addr}, 32'h5);
        tick();
        wren = 1'b0;
        #1;
        check("ram_wen_lo", {31'h0, ram_wEn}, 32'h0);
        load(32'h5, rd);
        check("ram_load", rd, 32'h1234);

        // three pushes, then drain
        wren = 1'b1;
        address_dmem = 32'h1000;
        data = 32'hA;
        #1;
        check("mmio_no_ramwen", {31'h0, ram_wEn}, 32'h0);
        tick();
        wren = 1'b0;
        store(32'h1000, 32'hB);
        store(32'h1000, 32'hC);
        load(32'h1001, rd);
        check("status_3", rd, 32'h18);
        tx_ready = 1'b1;
        #1;
        check("drain_v0", {31'h0, tx_valid}, 32'h1);
        check("drain_A", tx_data, 32'hA);
        tick();
        check("drain_B", tx_data, 32'hB);
        tick();
        check("drain_C", tx_data, 32'hC);
        tick();
        check("drain_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        load(32'h1001, rd);
        check("status_empty", rd, 32'h1);

        // overflow: 17 pushes into 16 slots
        for (int i = 0; i < 17; i++) store(32'h1000, 32'd100 + i);
        load(32'h1001, rd);
        check("status_ovf", rd, 32'h86);
        store(32'h1001, 32'h0);
        load(32'h1001, rd);
        check("status_ovf_clr", rd, 32'h82);
        tx_ready = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain_v", {31'h0, tx_valid}, 32'h1);
            check("ovf_drain_d", tx_data, 32'd100 + i);
            tick();
        end
        check("ovf_drain_end", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // full FIFO, simultaneous push and pop
        for (int i = 0; i < 16; i++) store(32'h1000, 32'd200 + i);
        tx_ready = 1'b1;
        store(32'h1000, 32'h999);
        tx_ready = 1'b0;
        load(32'h1001, rd);
        check("status_pp", rd, 32'h82);
        tx_ready = 1'b1;
        #1;
        for (int i = 1; i < 16; i++) begin
            check("pp_drain_d", tx_data, 32'd200 + i);
            tick();
        end
        check("pp_last_v", {31'h0, tx_valid}, 32'h1);
        check("pp_last_d", tx_data, 32'h999);
        tick();
        check("pp_end", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // scratch, cycles, unmapped
        store(32'h1003, 32'hDEADBEEF);
        load(32'h1003, rd);
        check("scratch", rd, 32'hDEADBEEF);
        store(32'h1002, 32'h0);
        repeat (9) tick();
        load(32'h1002, rd);
        check("cycles", rd, 32'd9);
        load(32'h2000, rd);
        check("unmapped", rd, 32'h0);
        load(32'h1005, rd);
        check("mmio_reserved", rd, 32'h0);
        load(32'h1000, rd);
        check("txdata_read", rd, 32'h0);

        // reset mid-drain
        for (int i = 0; i < 5; i++) store(32'h1000, 32'd50 + i);
        tx_ready = 1'b1;
        tick();
        tick();
        check("pre_rst_d", tx_data, 32'd52);
        load(32'h1003, rd);
        check("pre_rst_q", q_dmem, 32'hDEADBEEF);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_q", q_dmem, 32'h0);
        tx_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        load(32'h1001, rd);
        check("post_rst_status", rd, 32'h1);
        load(32'h1003, rd);
        check("post_rst_scratch", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
